// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the MIPS multiply/divide unit.
// Holds the op encodings, the FSM state type, the iteration count and the counter width.
package mips_muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mips_muldiv_if.sv
// Handshake and result bus between the MIPS datapath and the mul/div unit.
//   start/op/rs_val/rt_val : issue side, driven by the datapath (master)
//   busy/done/div_by_zero  : status, driven by the unit (slave)
//   hi/lo                  : architectural HI/LO registers
interface mips_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_val, rt_val,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mips_muldiv_step.sv
// One combinational iteration of the shared mul/div accumulator.
//   acc_i   : 2*WIDTH+1 accumulator
//             multiply: [2W:W] partial product high, [W-1:0] remaining multiplier bits
//             divide  : [2W:W] remainder,            [W-1:0] dividend / quotient bits
//   opnd_i  : multiplicand or divisor magnitude
//   div_i   : 1 selects the divide step
//   acc_o   : next accumulator (quotient bit position left 0)
//   q_bit_o : quotient bit of this iteration (0 for multiply)
module mips_muldiv_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             div_i,
  output logic [2*WIDTH:0] acc_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             q_bit;

  always_comb begin
    // Upper word never exceeds WIDTH bits before the add, so WIDTH+1 bits hold the sum.
    mul_sum = acc_i[0] ? (acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i}) : acc_i[2*WIDTH:WIDTH];
    rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
    trial   = {1'b0, rem_sh} - {2'b00, opnd_i};
    q_bit   = ~trial[WIDTH+1];
    if (div_i) begin
      acc_o   = {(q_bit ? trial[WIDTH:0] : rem_sh), acc_i[WIDTH-2:0], 1'b0};
      q_bit_o = q_bit;
    end else begin
      acc_o   = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO for the MIPS datapath.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of mips_muldiv_if (issue, status, HI/LO)
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one shift-add / shift-subtract iteration per cycle
// FIX    | sign correction, HI/LO written at end of cycle
// DONE   | done pulse; a new start is accepted here as in IDLE
module mips_muldiv_ctrl
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = mips_muldiv_pkg::ITER
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_muldiv_if.slave  bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH:0]   step_acc;
  logic               step_q_bit;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .div_i   (is_div_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // Signed ops (op[0]==0) work on magnitudes; 0x80000000 negates to itself, read unsigned.
    a_neg = ~bus.op[0] & bus.rs_val[WIDTH-1];
    b_neg = ~bus.op[0] & bus.rt_val[WIDTH-1];
    a_mag = a_neg ? -bus.rs_val : bus.rs_val;
    b_mag = b_neg ? -bus.rt_val : bus.rt_val;
    prod  = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          dz_d = bus.op[1] && (bus.rt_val == '0);
          if (bus.op[1] && (bus.rt_val == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_CALC;
            cnt_d     = '0;
            is_div_d  = bus.op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            opnd_d    = bus.op[1] ? b_mag : a_mag;
            acc_d     = {{(WIDTH+1){1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          end
        end
      end
      S_CALC: begin
        acc_d = {step_acc[2*WIDTH:1], step_acc[0] | step_q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed self-checking bench for mips_muldiv_ctrl.
module tb_mips_muldiv_ctrl;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Drives start for exactly one edge (E0); returns 1 ns after E0, i.e. in cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op = 2'($urandom); bus.rs_val = $urandom; bus.rt_val = $urandom;
  endtask

  // Counts cycles from 'first' at each negedge until done; -1 if the budget expires.
  task automatic wait_done(input int first, output int cyc);
    cyc = -1;
    for (int k = first; k < first + 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (bus.busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0)        begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", bus.div_by_zero); end
    if (bus.hi !== 32'h0)         begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    if (bus.lo !== 32'h0)         begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    rst_n = 1'b1;
  endtask

  // MULT 7 * -3 with cycle-exact busy/done; an ignored divide-by-zero start in cycle 10.
  task automatic test_mult;
    issue(MULT, 32'd7, 32'hFFFF_FFFD);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 11) bus.start = 1'b0;
      checks += 2;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy cycle=%0d got=%b exp=1", k, bus.busy); end
      if (bus.done !== (k == 34)) begin errors++; $display("FAIL mult_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 34)); end
      if (k == 20) begin
        checks++;
        if (bus.lo !== 32'h0) begin errors++; $display("FAIL mult_lo_stable got=%h exp=0", bus.lo); end
      end
      if (k == 10) begin
        bus.start = 1'b1; bus.op = DIVU; bus.rs_val = 32'd5; bus.rt_val = 32'd0;
      end
    end
    checks += 3;
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got=%h exp=ffffffeb", bus.lo); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL mult_dz got=%b exp=0", bus.div_by_zero); end
    @(negedge clk);
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_idle_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_idle_done got=%b exp=0", bus.done); end
  endtask

  // MULTU max*max, then DIV -7/2 issued in its DONE cycle.
  task automatic test_back_to_back;
    int cyc;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc);
    checks += 3;
    if (cyc != 34)                begin errors++; $display("FAIL multu_latency got=%0d exp=34", cyc); end
    if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
    if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
    bus.start = 1'b1; bus.op = DIV; bus.rs_val = 32'hFFFF_FFF9; bus.rt_val = 32'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
    @(negedge clk);
    checks += 3;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done got=%b exp=0", bus.done); end
    if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_hi_stable got=%h exp=fffffffe", bus.hi); end
    wait_done(2, cyc);
    checks += 3;
    if (cyc != 34)                begin errors++; $display("FAIL div_latency got=%0d exp=34", cyc); end
    if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); end
  endtask

  task automatic test_div_overflow;
    int cyc;
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, cyc);
    checks += 4;
    if (cyc != 34)                begin errors++; $display("FAIL divovf_latency got=%0d exp=34", cyc); end
    if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got=%h exp=80000000", bus.lo); end
    if (bus.hi !== 32'h0)         begin errors++; $display("FAIL divovf_hi got=%h exp=0", bus.hi); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL divovf_dz got=%b exp=0", bus.div_by_zero); end
  endtask

  task automatic test_div_by_zero;
    int cyc;
    issue(DIVU, 32'h0000_0451, 32'h0000_0020);
    wait_done(1, cyc);
    checks += 2;
    if (bus.lo !== 32'h22) begin errors++; $display("FAIL divu_lo got=%h exp=22", bus.lo); end
    if (bus.hi !== 32'h11) begin errors++; $display("FAIL divu_hi got=%h exp=11", bus.hi); end
    issue(DIVU, 32'd100, 32'd0);
    @(negedge clk);
    checks += 5;
    if (bus.done !== 1'b1)        begin errors++; $display("FAIL dz_done got=%b exp=1", bus.done); end
    if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", bus.div_by_zero); end
    if (bus.busy !== 1'b1)        begin errors++; $display("FAIL dz_busy got=%b exp=1", bus.busy); end
    if (bus.hi !== 32'h11)        begin errors++; $display("FAIL dz_hi got=%h exp=11", bus.hi); end
    if (bus.lo !== 32'h22)        begin errors++; $display("FAIL dz_lo got=%h exp=22", bus.lo); end
    @(negedge clk);
    checks += 3;
    if (bus.busy !== 1'b0)        begin errors++; $display("FAIL dz_idle_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0)        begin errors++; $display("FAIL dz_idle_done got=%b exp=0", bus.done); end
    if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got=%b exp=1", bus.div_by_zero); end
    issue(MULTU, 32'd2, 32'd3);
    @(negedge clk);
    checks++;
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", bus.div_by_zero); end
    wait_done(2, cyc);
    checks += 3;
    if (cyc != 34)         begin errors++; $display("FAIL multu_small_latency got=%0d exp=34", cyc); end
    if (bus.lo !== 32'd6)  begin errors++; $display("FAIL multu_small_lo got=%h exp=6", bus.lo); end
    if (bus.hi !== 32'd0)  begin errors++; $display("FAIL multu_small_hi got=%h exp=0", bus.hi); end
  endtask

  // MULTU 3*5, ignored start in cycle 10, reset asserted in cycle 20.
  task automatic test_reset_midop;
    int done_seen;
    issue(MULTU, 32'd3, 32'd5);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 11) begin
        bus.start = 1'b0;
        checks += 3;
        if (bus.busy !== 1'b1)        begin errors++; $display("FAIL ign_busy got=%b exp=1", bus.busy); end
        if (bus.done !== 1'b0)        begin errors++; $display("FAIL ign_done got=%b exp=0", bus.done); end
        if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL ign_dz got=%b exp=0", bus.div_by_zero); end
      end
      if (k == 21) begin
        rst_n = 1'b1;
        checks += 4;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", bus.done); end
        if (bus.hi !== 32'h0)  begin errors++; $display("FAIL rst_mid_hi got=%h exp=0", bus.hi); end
        if (bus.lo !== 32'h0)  begin errors++; $display("FAIL rst_mid_lo got=%h exp=0", bus.lo); end
      end
      if (k == 10) begin
        bus.start = 1'b1; bus.op = DIVU; bus.rs_val = 32'd9; bus.rt_val = 32'd0;
      end
      if (k == 20) rst_n = 1'b0;
    end
    done_seen = 0;
    for (int k = 22; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d active cycles exp=0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_overflow();
    test_div_by_zero();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
